// File: rtl/if_id_pipe_ctrl.sv
// IF->ID pipeline register and its flush/freeze/stall sequencing; 1-cycle capture, holds on mem_busy or hazard.
// Optional perf counters (stall_cnt, flush_cnt) are compiled in with IF_ID_PERF_EN.
module if_id_pipe_ctrl #(
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 1,
   parameter int          MAX_WAIT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        hazard,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        freeze_pc,
   output logic        bubble,
   output logic        flush_active,
`ifdef IF_ID_PERF_EN
   output logic        wait_timeout,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`else
   output logic        wait_timeout
`endif
);

   typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT);

   state_t     state;
   logic [2:0] flush_left;
   logic [7:0] wait_cnt;
   logic       stall_hz;

   // A hazard only matters when ID holds a real instruction.
   always_comb begin
      stall_hz     = hazard && id_valid;
      freeze_pc    = !branch_taken && (mem_busy || stall_hz);
      bubble       = !branch_taken && !mem_busy && stall_hz;
      flush_active = branch_taken || (state == FLUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         flush_left   <= '0;
         wait_cnt     <= '0;
         wait_timeout <= 1'b0;
         id_pc        <= '0;
         id_instr     <= NOP_INSTR;
         id_valid     <= 1'b0;
      end else if (branch_taken) begin
         id_pc    <= if_pc;
         id_instr <= NOP_INSTR;
         id_valid <= 1'b0;
         wait_cnt <= '0;
         if (FLUSH_CYCLES > 1) begin
            state      <= FLUSH;
            flush_left <= FLUSH_LOAD;
         end else begin
            state <= RUN;
         end
      end else if (mem_busy) begin
         // Register and flush count are frozen; only the wait watchdog advances.
         if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 8'd1;
         if (wait_cnt >= WAIT_MAX - 8'd1)
            wait_timeout <= 1'b1;
         if (state != FLUSH)
            state <= MEMWAIT;
      end else begin
         wait_cnt <= '0;
         if (stall_hz) begin
            if (state == MEMWAIT)
               state <= RUN;
         end else if (state == FLUSH) begin
            id_pc      <= if_pc;
            id_instr   <= NOP_INSTR;
            id_valid   <= 1'b0;
            flush_left <= flush_left - 3'd1;
            if (flush_left == 3'd1)
               state <= RUN;
         end else begin
            id_pc    <= if_pc;
            id_instr <= if_instr;
            id_valid <= 1'b1;
            state    <= RUN;
         end
      end
   end

`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (freeze_pc && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (branch_taken && (flush_cnt != 32'hFFFF_FFFF))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Directed bench for if_id_pipe_ctrl with FLUSH_CYCLES=2, MAX_WAIT=4 and a non-zero NOP word.
module tb_if_id_pipe_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc, if_instr;
   logic        hazard, branch_taken, mem_busy;
   logic [31:0] id_pc, id_instr;
   logic        id_valid, freeze_pc, bubble, flush_active, wait_timeout;
`ifdef IF_ID_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   if_id_pipe_ctrl #(.NOP_INSTR(NOP), .FLUSH_CYCLES(2), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
      .hazard(hazard), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
      .freeze_pc(freeze_pc), .bubble(bubble), .flush_active(flush_active),
`ifdef IF_ID_PERF_EN
      .wait_timeout(wait_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
      .wait_timeout(wait_timeout)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
      if_pc    = pc;
      if_instr = instr;
      #1;
   endtask

   initial begin
      rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
      if_pc = '0; if_instr = '0;
      #12;
      check("rst_pc", id_pc, 32'h0);
      check("rst_instr", id_instr, NOP);
      check("rst_valid", {31'd0, id_valid}, 32'd0);
      check("rst_timeout", {31'd0, wait_timeout}, 32'd0);
      check("rst_outs", {29'd0, freeze_pc, bubble, flush_active}, 32'd0);
      rst = 1'b0;

      // streaming capture
      drive(32'h0, 32'hA);  step();
      check("s1_pc", id_pc, 32'h0);
      check("s1_instr", id_instr, 32'hA);
      check("s1_valid", {31'd0, id_valid}, 32'd1);
      drive(32'h4, 32'hB);  step();
      check("s2_pc", id_pc, 32'h4);
      check("s2_instr", id_instr, 32'hB);

      // two-cycle hazard stall with B in ID
      drive(32'h8, 32'hC); hazard = 1'b1; #1;
      check("hz_freeze_bubble", {30'd0, freeze_pc, bubble}, 32'd3);
      step();
      check("hz_hold1", id_pc, 32'h4);
      check("hz_outs1", {30'd0, freeze_pc, bubble}, 32'd3);
      step();
      check("hz_hold2", id_pc, 32'h4);
      hazard = 1'b0; #1;
      check("hz_release", {30'd0, freeze_pc, bubble}, 32'd0);
      step();
      check("hz_c_pc", id_pc, 32'h8);
      check("hz_c_instr", id_instr, 32'hC);

      // branch with simultaneous hazard: branch wins
      drive(32'hC, 32'hD); branch_taken = 1'b1; hazard = 1'b1; #1;
      check("br_outs", {29'd0, freeze_pc, bubble, flush_active}, 32'd1);
      step();
      check("br_valid", {31'd0, id_valid}, 32'd0);
      check("br_instr", id_instr, NOP);
      branch_taken = 1'b0; hazard = 1'b1;
      drive(32'h10, 32'hE);
      check("fl_active", {31'd0, flush_active}, 32'd1);
      check("fl_hz_ignored", {30'd0, freeze_pc, bubble}, 32'd0);
      step();
      check("fl_valid", {31'd0, id_valid}, 32'd0);
      check("fl_instr", id_instr, NOP);
      hazard = 1'b0;
      drive(32'h100, 32'h77);
      check("fl_done", {31'd0, flush_active}, 32'd0);
      step();
      check("tgt_pc", id_pc, 32'h100);
      check("tgt_instr", id_instr, 32'h77);
      check("tgt_valid", {31'd0, id_valid}, 32'd1);
`ifdef IF_ID_PERF_EN
      check("perf_stall", stall_cnt, 32'd2);
      check("perf_flush", flush_cnt, 32'd1);
`endif

      // memory wait: 5 busy cycles, hazard alongside resolves as mem_busy
      drive(32'h104, 32'h88); mem_busy = 1'b1; hazard = 1'b1; #1;
      check("mw_outs", {30'd0, freeze_pc, bubble}, 32'd2);
      for (int i = 1; i <= 5; i++) begin
         step();
         hazard = 1'b0;
         check($sformatf("mw_hold%0d", i), id_pc, 32'h100);
         check($sformatf("mw_to%0d", i), {31'd0, wait_timeout}, (i >= 4) ? 32'd1 : 32'd0);
      end
      mem_busy = 1'b0; #1;
      step();
      check("mw_load", id_pc, 32'h104);
      check("mw_instr", id_instr, 32'h88);
      check("mw_sticky", {31'd0, wait_timeout}, 32'd1);

      // reset in the middle of a flush, no clock edge
      drive(32'h200, 32'h99); branch_taken = 1'b1; #1;
      step();
      branch_taken = 1'b0; #1;
      rst = 1'b1; #1;
      check("rf_valid", {31'd0, id_valid}, 32'd0);
      check("rf_instr", id_instr, NOP);
      check("rf_pc", id_pc, 32'h0);
      check("rf_flush", {31'd0, flush_active}, 32'd0);
      check("rf_timeout", {31'd0, wait_timeout}, 32'd0);
      rst = 1'b0;
      drive(32'h300, 32'hAA);
      step();
      check("rf_first_pc", id_pc, 32'h300);
      check("rf_first_valid", {31'd0, id_valid}, 32'd1);

      // reset in the middle of a memory wait clears the watchdog
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) step();
      #1 rst = 1'b1; #1;
      check("rm_instr", id_instr, NOP);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("rm_timeout", {31'd0, wait_timeout}, 32'd0);
      mem_busy = 1'b0;
      drive(32'h400, 32'hBB);
      step();
      check("rm_first_pc", id_pc, 32'h400);
      check("rm_first_instr", id_instr, 32'hBB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
